dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
Shares the single-port 4 KB data memory between two requesters: port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
Sits between both requesters and the data memory and drives its word address, write data, write enable, byte mode and byte select.
- Arbitration is registered, round-robin.
- A requester may lock the grant for back-to-back word/byte accesses, bounded by a lock budget.
- Memory read is combinational and write is on the clock edge, so each granted access completes in one cycle.

Parameters:
MAX_LOCK, 16, max consecutive grant cycles one port may hold while lock is asserted (1..31)
LCW, 5, width of the lock counter; must satisfy 2^LCW > MAX_LOCK

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous, active-high reset
req0, req1  in  1  access request; held with its command stable until ack sampled high
lock0, lock1  in  1  requester will present another access in the cycle after ack
we0, we1  in  1  write (1) / read (0)
addr0, addr1  in  10  word address [11:2]
wdata0, wdata1  in  32  write data (byte writes use [7:0])
bmode0, bmode1  in  1  byte access
bsel0, bsel1  in  2  byte lane within the word
ack0, ack1  out  1  access performed this cycle
rdata  out  32  read data, valid when either ack is high (= m_dout)
gnt  out  2  one-hot current grant; 00 when idle
m_addr  out  10  to memory addr
m_din  out  32  to memory din
m_we  out  1  to memory we
m_bmode  out  1  to memory bmode
m_bsel  out  2  to memory bsel
m_dout  in  32  from memory dout (sign-extended in byte mode by memory)

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, last=1 (port 0 wins the first tie), lock_cnt=0.
  - All outputs then read ack=00, gnt=00, m_we=0, m_addr/m_din/m_bsel=0, m_bmode=0.
  - Reset during GNT aborts the access: no ack, no write after that edge.
- States: IDLE, GNT0, GNT1 (encoding in package).
- IDLE:
  - Memory outputs are 0 and m_we=0.
  - At posedge: req0 & !req1 → GNT0; req1 & !req0 → GNT1; both → the port != last; none → stay.
  - Entering GNTx sets last=x and lock_cnt=1.
- GNTx (combinational drive):
  - m_* = port x command; m_we = wex & reqx; ackx = reqx; other ack=0.
  - rdata = m_dout.
- Write commits on the posedge ending the GNT cycle.
- Latency: req rising before posedge N → ack in cycle N..N+1 (1 cycle if idle and uncontested). Unlocked back-to-back from one port costs 2 cycles per access, because IDLE re-arbitrates.
- Leaving GNTx at posedge:
  - reqx=0 (requester aborted) → IDLE; no write occurred because m_we was gated.
  - reqx & lockx & lock_cnt < MAX_LOCK → stay GNTx, lock_cnt++. The requester must present its next command in the following cycle.
  - Otherwise → IDLE, lock_cnt=0.
- Lock budget exhausted while the other port waits: the waiting port wins the next IDLE arbitration because last=x.
- The lock is ignored when entering GNT; lock_cnt counts grant cycles, including the first.
- A port in GNT never sees the other port's request change its grant. Pending requests wait; no request is dropped.
- Requester obligations (checked by the bench, not the RTL): command stable while req high and before ack; req deasserted or next command presented after ack.

Decomposition:
- Package dm_arb_pkg: state localparams (ST_IDLE, ST_GNT0, ST_GNT1), port indices P_CPU=0 and P_DMA=1, width constants AW=10 and DW=32.
- One sub-module is natural: rr_pick2. It is the combinational two-way round-robin pick from (req0, req1, last) to winner/valid, reused by the later I/O-bus arbiter.
- Mux, FSM and lock counter stay in dm_arbiter.

Test Plan:
- Reset, then req0 write addr=0x004, wdata=0xDEADBEEF, bmode=0 → gnt=01 the cycle after, ack0=1 for 1 cycle, m_we=1; a later port-1 read of 0x004 returns rdata=0xDEADBEEF.
- req0 and req1 both asserted in the same cycle after reset → port 0 granted first, then IDLE, then port 1. With both held continuously, grants alternate 0,1,0,1.
- Port 1 byte write bmode=1, bsel=2, wdata=0x80 to 0x010 (preloaded 0x11223344) → word becomes 0x11803344; port 0 byte read bsel=2 → rdata=0xFFFFFF80.
- Port 1 lock=1 with 20 consecutive reads while req0 is pending → exactly MAX_LOCK=16 ack1 cycles, then IDLE, then port 0 is granted before port 1 resumes.
- Port 0 drops req0 in the GNT0 cycle with we0=1 → no ack0, m_we=0, memory unchanged, state returns to IDLE.
- rst asserted during a locked port-1 burst → at the next cycle gnt=00, ack=00, m_we=0; after release, a tie grants port 0.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } dm_state_t;

    localparam int P_CPU = 0;
    localparam int P_DMA = 1;
    localparam int AW    = 10;
    localparam int DW    = 32;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin pick
// ports: req0/req1 requests, last = port granted most recently,
//        winner = chosen port index, valid = any request present
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);

    // On a tie the port that did not win last time goes first.
    assign winner = (req0 & req1) ? ~last : req1;
    assign valid  = req0 | req1;

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin arbiter with grant lock for the shared data memory
// ports: clk, rst (sync, active-high)
//        req/lock/we/addr/wdata/bmode/bsel 0/1 - requester commands, ack0/ack1 - access done
//        rdata - read data (m_dout), gnt - one-hot current grant
//        m_addr/m_din/m_we/m_bmode/m_bsel - memory command, m_dout - memory read data
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MAX_LOCK = 16,
    parameter int LCW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          bmode0,
    input  logic          bmode1,
    input  logic [1:0]    bsel0,
    input  logic [1:0]    bsel1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [1:0]    gnt,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_din,
    output logic          m_we,
    output logic          m_bmode,
    output logic [1:0]    m_bsel,
    input  logic [DW-1:0] m_dout
);

    localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);
    localparam logic [LCW-1:0] LOCK_ONE = LCW'(1);

    dm_state_t      state_q, state_d;
    logic           last_q, last_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           pick_winner, pick_valid;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Memory read is combinational, so the read data is passed straight through.
    assign rdata = m_dout;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        gnt        = 2'b00;
        ack0       = 1'b0;
        ack1       = 1'b0;
        m_addr     = '0;
        m_din      = '0;
        m_we       = 1'b0;
        m_bmode    = 1'b0;
        m_bsel     = 2'b00;

        case (state_q)
            ST_IDLE: begin
                // Lock is not looked at here: the first grant cycle counts as 1.
                if (pick_valid) begin
                    state_d    = pick_winner ? ST_GNT1 : ST_GNT0;
                    last_d     = pick_winner;
                    lock_cnt_d = LOCK_ONE;
                end
            end

            ST_GNT0: begin
                gnt     = 2'b01;
                m_addr  = addr0;
                m_din   = wdata0;
                m_bmode = bmode0;
                m_bsel  = bsel0;
                // Gating by req keeps an aborted write out of memory; gating by
                // rst keeps a reset cycle from completing the access.
                m_we    = we0 & req0 & ~rst;
                ack0    = req0 & ~rst;
                if (req0 & lock0 & (lock_cnt_q < LOCK_MAX)) begin
                    lock_cnt_d = lock_cnt_q + LOCK_ONE;
                end else begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            end

            ST_GNT1: begin
                gnt     = 2'b10;
                m_addr  = addr1;
                m_din   = wdata1;
                m_bmode = bmode1;
                m_bsel  = bsel1;
                m_we    = we1 & req1 & ~rst;
                ack1    = req1 & ~rst;
                if (req1 & lock1 & (lock_cnt_q < LOCK_MAX)) begin
                    lock_cnt_d = lock_cnt_q + LOCK_ONE;
                end else begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter with memory and reference model
module tb_dm_arbiter;

    localparam int MAX_LOCK = 16;
    localparam int BOUND    = 2 * MAX_LOCK + 4;

    logic        clk;
    logic        rst;
    logic        preload;
    logic        req   [2];
    logic        lock  [2];
    logic        we    [2];
    logic [9:0]  addr  [2];
    logic [31:0] wdata [2];
    logic        bmode [2];
    logic [1:0]  bsel  [2];
    logic        ack0, ack1;
    logic [31:0] rdata;
    logic [1:0]  gnt;
    logic [9:0]  m_addr;
    logic [31:0] m_din;
    logic        m_we;
    logic        m_bmode;
    logic [1:0]  m_bsel;
    logic [31:0] m_dout;

    dm_arbiter #(.MAX_LOCK(MAX_LOCK), .LCW(5)) dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .req1(req[1]), .lock0(lock[0]), .lock1(lock[1]),
        .we0(we[0]), .we1(we[1]), .addr0(addr[0]), .addr1(addr[1]),
        .wdata0(wdata[0]), .wdata1(wdata[1]), .bmode0(bmode[0]), .bmode1(bmode[1]),
        .bsel0(bsel[0]), .bsel1(bsel[1]), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .gnt(gnt), .m_addr(m_addr), .m_din(m_din), .m_we(m_we),
        .m_bmode(m_bmode), .m_bsel(m_bsel), .m_dout(m_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'h11223344;
        return ((32'(i) + 32'd1) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // Memory environment: combinational read (byte reads sign-extended), write on posedge.
    logic [31:0] mem [0:1023];
    logic [31:0] mw;
    logic [7:0]  mb;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (m_we) begin
            if (m_bmode) mem[m_addr][m_bsel*8 +: 8] <= m_din[7:0];
            else         mem[m_addr] <= m_din;
        end
    end

    always_comb begin
        mw     = mem[m_addr];
        mb     = mw[m_bsel*8 +: 8];
        m_dout = m_bmode ? {{24{mb[7]}}, mb} : mw;
    end

    // Reference model state.
    logic [31:0] ref_mem [0:1023];
    int m_owner;
    int m_last;
    int m_held;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]  obs_gnt;
    logic [1:0]  obs_ack;
    logic        obs_mwe;
    logic [31:0] obs_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_read(input logic [9:0] a, input logic bm, input logic [1:0] bs);
        logic [31:0] w;
        logic [7:0]  b;
        w = ref_mem[a];
        b = w[bs*8 +: 8];
        return bm ? {{24{b[7]}}, b} : w;
    endfunction

    task automatic model_step();
        logic [1:0]  e_gnt;
        logic [1:0]  e_ack;
        logic        e_we;
        logic [9:0]  e_addr;
        logic [31:0] e_din;
        logic        e_bm;
        logic [1:0]  e_bs;
        int p;
        e_gnt = 2'b00; e_ack = 2'b00; e_we = 1'b0;
        e_addr = '0; e_din = '0; e_bm = 1'b0; e_bs = 2'b00;
        p = (m_owner < 0) ? 0 : m_owner;
        if (m_owner >= 0) begin
            e_gnt    = (p == 0) ? 2'b01 : 2'b10;
            e_ack[p] = req[p] && !rst;
            e_we     = we[p] && req[p] && !rst;
            e_addr   = addr[p];
            e_din    = wdata[p];
            e_bm     = bmode[p];
            e_bs     = bsel[p];
        end
        check("gnt", gnt, e_gnt);
        check("ack", {ack1, ack0}, e_ack);
        check("m_we", m_we, e_we);
        check("m_addr", m_addr, e_addr);
        check("m_din", m_din, e_din);
        check("m_bmode_bsel", {m_bmode, m_bsel}, {e_bm, e_bs});
        if (e_ack != 2'b00 && !we[p])
            check("rdata", rdata, ref_read(addr[p], bmode[p], bsel[p]));
        if (e_we) begin
            if (e_bm) ref_mem[e_addr][e_bs*8 +: 8] = e_din[7:0];
            else      ref_mem[e_addr] = e_din;
        end
        obs_gnt = gnt; obs_ack = {ack1, ack0}; obs_mwe = m_we; obs_rdata = rdata;

        if (rst) begin
            m_owner = -1; m_last = 1; m_held = 0;
        end else if (m_owner < 0) begin
            if (req[0] || req[1]) begin
                m_owner = (req[0] && req[1]) ? 1 - m_last : (req[0] ? 0 : 1);
                m_last  = m_owner;
                m_held  = 1;
            end
        end else if (req[p] && lock[p] && m_held < MAX_LOCK) begin
            m_held++;
        end else begin
            m_owner = -1; m_held = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int p, input bit w, input logic [9:0] a, input logic [31:0] d,
                           input bit bm, input logic [1:0] bs, input bit lk);
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        bmode[p] = bm; bsel[p] = bs; lock[p] = lk;
    endtask

    task automatic new_cmd(input int p);
        set_cmd(p, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), $urandom,
                ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
    endtask

    task automatic do_access(input int p, input bit w, input logic [9:0] a, input logic [31:0] d,
                             input bit bm, input logic [1:0] bs,
                             output logic [31:0] rd, output int lat);
        lat = 0;
        set_cmd(p, w, a, d, bm, bs, 1'b0);
        do begin
            cycle();
            lat++;
        end while (!obs_ack[p] && lat < 64);
        check("access_done", obs_ack[p], 1'b1);
        rd = obs_rdata;
        req[p] = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;
    logic [1:0]  tr [0:31];
    int          issued;
    int          n_ack1;
    int          n10;
    bit          busy  [2];
    int          waitc [2];

    initial begin
        rst = 1'b1; preload = 1'b1;
        for (int p = 0; p < 2; p++) begin
            req[p] = 0; lock[p] = 0; we[p] = 0; addr[p] = '0;
            wdata[p] = '0; bmode[p] = 0; bsel[p] = '0;
            busy[p] = 0; waitc[p] = 0;
        end
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; preload = 1'b0;
        m_owner = -1; m_last = 1; m_held = 0;

        // Reset state.
        cycle();
        check("reset_gnt", obs_gnt, 2'b00);
        check("reset_ack", obs_ack, 2'b00);
        check("reset_mwe", obs_mwe, 1'b0);

        // Uncontested word write then cross-port read.
        do_access(0, 1'b1, 10'h004, 32'hDEADBEEF, 1'b0, 2'd0, rd, lat);
        check("wr_latency", lat, 2);
        check("wr_gnt", obs_gnt, 2'b01);
        check("wr_mwe", obs_mwe, 1'b1);
        cycle();
        check("ack_one_cycle", obs_ack, 2'b00);
        do_access(1, 1'b0, 10'h004, 32'h0, 1'b0, 2'd0, rd, lat);
        check("rd_back", rd, 32'hDEADBEEF);

        // Tie after reset, both held: 0,idle,1,idle,0.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_cmd(0, 1'b0, 10'd1, 32'h0, 1'b0, 2'd0, 1'b0);
        set_cmd(1, 1'b0, 10'd2, 32'h0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            tr[i] = obs_gnt;
        end
        check("tie_0", tr[0], 2'b00);
        check("tie_1", tr[1], 2'b01);
        check("tie_2", tr[2], 2'b00);
        check("tie_3", tr[3], 2'b10);
        check("tie_4", tr[4], 2'b00);
        check("tie_5", tr[5], 2'b01);
        req[0] = 0; req[1] = 0;
        cycle();

        // Byte write lane 2, then signed byte read and word read.
        do_access(1, 1'b1, 10'h010, 32'h00000080, 1'b1, 2'd2, rd, lat);
        do_access(0, 1'b0, 10'h010, 32'h0, 1'b1, 2'd2, rd, lat);
        check("byte_rd", rd, 32'hFFFFFF80);
        do_access(0, 1'b0, 10'h010, 32'h0, 1'b0, 2'd0, rd, lat);
        check("byte_word", rd, 32'h11803344);

        // Port 1 locked burst of 20 reads with port 0 pending.
        set_cmd(1, 1'b0, 10'd0, 32'h0, 1'b0, 2'd0, 1'b1);
        issued = 1; n_ack1 = 0;
        cycle();
        set_cmd(0, 1'b0, 10'd3, 32'h0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            cycle();
            tr[i] = obs_gnt;
            if (obs_ack[0]) req[0] = 0;
            if (obs_ack[1]) begin
                n_ack1++;
                if (issued < 20) begin
                    addr[1] = 10'(issued);
                    issued++;
                    lock[1] = (issued < 20);
                end else begin
                    req[1] = 0;
                end
            end
        end
        n10 = 0;
        for (int i = 0; i < 16; i++) if (tr[i] == 2'b10) n10++;
        check("lock_burst_len", n10, 16);
        check("lock_then_idle", tr[16], 2'b00);
        check("lock_then_p0", tr[17], 2'b01);
        check("p1_resumes", tr[19], 2'b10);
        check("no_drop", n_ack1, 20);

        // Aborted write in the grant cycle.
        set_cmd(0, 1'b1, 10'd5, 32'hCAFEF00D, 1'b0, 2'd0, 1'b0);
        cycle();
        req[0] = 0;
        cycle();
        check("abort_gnt", obs_gnt, 2'b01);
        check("abort_ack", obs_ack, 2'b00);
        check("abort_mwe", obs_mwe, 1'b0);
        cycle();
        check("abort_idle", obs_gnt, 2'b00);
        check("abort_mem", mem[5], init_word(5));

        // Reset during a locked port-1 burst.
        set_cmd(1, 1'b0, 10'd7, 32'h0, 1'b0, 2'd0, 1'b1);
        cycle();
        cycle();
        check("burst_running", obs_ack, 2'b10);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_cmd(0, 1'b0, 10'd8, 32'h0, 1'b0, 2'd0, 1'b0);
        cycle();
        check("post_rst_gnt", obs_gnt, 2'b00);
        check("post_rst_ack", obs_ack, 2'b00);
        check("post_rst_mwe", obs_mwe, 1'b0);
        cycle();
        check("post_rst_tie", obs_gnt, 2'b01);
        req[0] = 0; req[1] = 0; lock[1] = 0;
        cycle();
        cycle();

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (busy[p]) begin
                    if (obs_ack[p]) begin
                        check("wait_bound", (waitc[p] <= BOUND), 1'b1);
                        waitc[p] = 0;
                        if (lock[p]) new_cmd(p);
                        else begin req[p] = 0; busy[p] = 0; end
                    end else if ($urandom_range(0, 63) == 0) begin
                        req[p] = 0; busy[p] = 0; waitc[p] = 0;
                    end else begin
                        waitc[p]++;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    new_cmd(p);
                    busy[p] = 1; waitc[p] = 0;
                end
            end
            cycle();
        end
        req[0] = 0; req[1] = 0;
        repeat (3) cycle();
        for (int i = 0; i < 32; i++) check("mem_final", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
